// File: rtl/cla_divider_8bit.sv
// Sequential unsigned restoring divider: one quotient bit per clock, trial
// subtraction formed as P' + ~D + 1 through 4-bit carry-lookahead groups.
module cla_divider_8bit #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int unsigned NG = (W + 4) / 4;  // ceil((W+1)/4) for W a multiple of 4
    localparam int unsigned NB = 4 * NG;
    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_next;
    logic [W-1:0]  p;
    logic [W-1:0]  q_sh;
    logic [W-1:0]  d;
    logic [CW-1:0] cnt;

    logic [W:0]    p_shift;
    logic [NB-1:0] op_a, op_b, bp, bg, bc;
    logic [NG-1:0] grp_p, grp_g;
    logic [NG:0]   gc;
    logic [W-1:0]  trial;
    logic          no_borrow;
    logic [W-1:0]  p_iter, q_iter;
    logic          zero_div;

    assign zero_div = (divisor == '0);

    // After each restore P < D, so P fits in W bits; only the shifted value needs W+1.
    always_comb begin
        p_shift = {p, q_sh[W-1]};
        op_a = '0;
        op_b = '0;
        op_a[W:0] = p_shift;
        op_b[W:0] = ~{1'b0, d};
        bp = op_a ^ op_b;
        bg = op_a & op_b;
        grp_p = '0;
        grp_g = '0;
        gc = '0;
        bc = '0;
        gc[0] = 1'b1;
        for (int unsigned k = 0; k < NG; k++) begin
            grp_g[k] = bg[4*k+3]
                     | (bp[4*k+3] & bg[4*k+2])
                     | (bp[4*k+3] & bp[4*k+2] & bg[4*k+1])
                     | (bp[4*k+3] & bp[4*k+2] & bp[4*k+1] & bg[4*k]);
            grp_p[k] = &bp[4*k +: 4];
            gc[k+1]  = grp_g[k] | (grp_p[k] & gc[k]);
            bc[4*k]   = gc[k];
            bc[4*k+1] = bg[4*k] | (bp[4*k] & gc[k]);
            bc[4*k+2] = bg[4*k+1] | (bp[4*k+1] & bg[4*k])
                      | (bp[4*k+1] & bp[4*k] & gc[k]);
            bc[4*k+3] = bg[4*k+2] | (bp[4*k+2] & bg[4*k+1])
                      | (bp[4*k+2] & bp[4*k+1] & bg[4*k])
                      | (bp[4*k+2] & bp[4*k+1] & bp[4*k] & gc[k]);
        end
        trial     = bp[W-1:0] ^ bc[W-1:0];
        no_borrow = bc[W+1];
        p_iter    = no_borrow ? trial : p_shift[W-1:0];
        q_iter    = {q_sh[W-2:0], no_borrow};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) state_next = zero_div ? DONE : RUN;
                else       state_next = IDLE;
            end
            RUN:     if (cnt == '0) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // The RUN cycle that finds the counter at zero performs no iteration; it only publishes results.
    always_ff @(posedge clk) begin
        if (rst) begin
            p           <= '0;
            q_sh        <= '0;
            d           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (zero_div) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            d           <= divisor;
                            p           <= '0;
                            q_sh        <= dividend;
                            cnt         <= CW'(W);
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (cnt != '0) begin
                        p    <= p_iter;
                        q_sh <= q_iter;
                        cnt  <= cnt - 1'b1;
                    end else begin
                        quotient  <= q_sh;
                        remainder <= p;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_divider_8bit.sv
// Directed self-checking bench for cla_divider_8bit (W=8).
module tb_cla_divider_8bit;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [7:0] dividend, divisor;
    logic       busy, done, div_by_zero;
    logic [7:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    cla_divider_8bit #(.W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Called at a negedge: drives a one-cycle start, then watches negedges.
    // done_cyc = index of the negedge showing done (1 = just after the accepting edge), 0 on timeout.
    // Nonzero divisor expects 10 (done after edge k+9), zero divisor expects 1.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int done_cyc,
                          output bit busy_ok, output logic [7:0] q, output logic [7:0] r,
                          output logic z);
        done_cyc = 0;
        busy_ok  = 1'b1;
        q = 8'hxx;
        r = 8'hxx;
        z = 1'bx;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        for (int i = 1; i <= 40; i++) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                done_cyc = i;
                q = quotient;
                r = remainder;
                z = div_by_zero;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b q=%0d r=%0d, expected all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        // start on the same edge as reset must be ignored
        start = 1'b1; dividend = 8'd5; divisor = 8'd1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_beats_start: got busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_basic;
        int c; bit bok; logic [7:0] q, r; logic z;
        @(negedge clk);
        run_op(8'd200, 8'd7, c, bok, q, r, z);
        checks++;
        if (c !== 10) begin errors++; $display("FAIL basic_latency: got %0d expected 10", c); end
        checks++;
        if (q !== 8'd28 || r !== 8'd4 || z !== 1'b0) begin
            errors++; $display("FAIL basic_result: got q=%0d r=%0d dbz=%b expected 28 4 0", q, r, z);
        end
        checks++;
        if (bok !== 1'b1) begin errors++; $display("FAIL basic_busy: got busy dropped, expected high"); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || quotient !== 8'd28 || remainder !== 8'd4) begin
            errors++;
            $display("FAIL basic_hold: got done=%b busy=%b q=%0d r=%0d expected 0 0 28 4",
                     done, busy, quotient, remainder);
        end
    endtask

    task automatic test_edges;
        logic [7:0] ta [4] = '{8'd255, 8'd5, 8'd255, 8'd0};
        logic [7:0] tb [4] = '{8'd1,   8'd9, 8'd255, 8'd3};
        logic [7:0] tq [4] = '{8'd255, 8'd0, 8'd1,   8'd0};
        logic [7:0] tr [4] = '{8'd0,   8'd5, 8'd0,   8'd0};
        int c; bit bok; logic [7:0] q, r; logic z;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            run_op(ta[i], tb[i], c, bok, q, r, z);
            checks++;
            if (c !== 10 || q !== tq[i] || r !== tr[i] || z !== 1'b0) begin
                errors++;
                $display("FAIL edge_%0d_%0d: got lat=%0d q=%0d r=%0d dbz=%b expected 10 %0d %0d 0",
                         ta[i], tb[i], c, q, r, z, tq[i], tr[i]);
            end
        end
    endtask

    task automatic test_div_zero;
        int c; bit bok; logic [7:0] q, r; logic z;
        @(negedge clk);
        run_op(8'h80, 8'h00, c, bok, q, r, z);
        checks++;
        if (c !== 1) begin errors++; $display("FAIL dbz_latency: got %0d expected 1", c); end
        checks++;
        if (q !== 8'hFF || r !== 8'h80 || z !== 1'b1) begin
            errors++; $display("FAIL dbz_result: got q=%h r=%h dbz=%b expected ff 80 1", q, r, z);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || div_by_zero !== 1'b1 || quotient !== 8'hFF) begin
            errors++;
            $display("FAIL dbz_hold: got done=%b dbz=%b q=%h expected 0 1 ff", done, div_by_zero, quotient);
        end
        run_op(8'd9, 8'd2, c, bok, q, r, z);
        checks++;
        if (c !== 10 || q !== 8'd4 || r !== 8'd1 || z !== 1'b0) begin
            errors++;
            $display("FAIL dbz_clear: got lat=%0d q=%0d r=%0d dbz=%b expected 10 4 1 0", c, q, r, z);
        end
    endtask

    task automatic test_start_during_run;
        int dones = 0;
        int done_at = 0;
        logic [7:0] q = 8'hxx, r = 8'hxx;
        @(negedge clk);
        dividend = 8'd100; divisor = 8'd3; start = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin dones++; done_at = i; q = quotient; r = remainder; end
            if (i == 1) start = 1'b0;
            if (i == 4) begin start = 1'b1; dividend = 8'd50; divisor = 8'd5; end
            if (i == 5) start = 1'b0;
        end
        checks++;
        if (dones !== 1 || done_at !== 10) begin
            errors++; $display("FAIL run_start_done: got %0d dones at %0d expected 1 at 10", dones, done_at);
        end
        checks++;
        if (q !== 8'd33 || r !== 8'd1) begin
            errors++; $display("FAIL run_start_result: got q=%0d r=%0d expected 33 1", q, r);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL run_start_queued: got busy=%b expected 0", busy); end
    endtask

    task automatic test_back_to_back;
        int c; bit bok; logic [7:0] q, r; logic z;
        @(negedge clk);
        run_op(8'd10, 8'd3, c, bok, q, r, z);
        checks++;
        if (c !== 10 || q !== 8'd3 || r !== 8'd1) begin
            errors++; $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d expected 10 3 1", c, q, r);
        end
        run_op(8'd77, 8'd8, c, bok, q, r, z);
        checks++;
        if (c !== 10 || q !== 8'd9 || r !== 8'd5 || bok !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d busy_ok=%b expected 10 9 5 1", c, q, r, bok);
        end
    endtask

    task automatic test_reset_mid;
        int c; bit bok; logic [7:0] q, r; logic z;
        int dones = 0;
        @(negedge clk);
        dividend = 8'd100; divisor = 8'd3; start = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) dones++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 19'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got busy=%b done=%b dbz=%b q=%0d r=%0d expected all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL reset_mid_nodone: got %0d dones expected 0", dones); end
        run_op(8'd13, 8'd4, c, bok, q, r, z);
        checks++;
        if (c !== 10 || q !== 8'd3 || r !== 8'd1) begin
            errors++; $display("FAIL reset_mid_after: got lat=%0d q=%0d r=%0d expected 10 3 1", c, q, r);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_div_zero();
        test_start_during_run();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
